// File: rtl/sum_normalize_round59_if.sv
// Handshake and data bundle for the sum normalize/round stage.
// Input side: in_valid/in_ready with sum_in/exp_in.
// Output side: out_valid/out_ready with mantissa, exponent and flags.
// Optional NORM_INEXACT_EN adds inexact_out.
interface sum_normalize_round59_if #(
    parameter int SUM_W  = 59,
    parameter int MANT_W = 27,
    parameter int EXP_W  = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [SUM_W-1:0]  sum_in;
    logic [EXP_W-1:0]  exp_in;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] mant_out;
    logic [EXP_W-1:0]  exp_out;
    logic              zero_out;
    logic              ovf_out;
    logic              unf_out;
`ifdef NORM_INEXACT_EN
    logic              inexact_out;
`endif

    // Producer/consumer side (the environment around the stage)
    modport master (
        output in_valid, sum_in, exp_in, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, zero_out, ovf_out, unf_out
`ifdef NORM_INEXACT_EN
        , input inexact_out
`endif
    );

    // Stage side
    modport slave (
        input  in_valid, sum_in, exp_in, out_ready,
        output in_ready, out_valid, mant_out, exp_out, zero_out, ovf_out, unf_out
`ifdef NORM_INEXACT_EN
        , output inexact_out
`endif
    );
endinterface

// File: rtl/sum_normalize_round59.sv
// Two-stage normalize-and-round stage following the unsigned sum adder.
// S1 registers the sum, exponent, leading-zero count and zero flag.
// S2 left-justifies, rounds to nearest-even, adjusts the exponent and flags
// range overflow/underflow. Full-throughput valid/ready on both sides.
// Optional macro NORM_INEXACT_EN adds the inexact_out flag.
module sum_normalize_round59 #(
    parameter int SUM_W  = 59,
    parameter int MANT_W = 27,
    parameter int EXP_W  = 10
) (
    input logic                    clk,
    input logic                    reset,
    sum_normalize_round59_if.slave bus
);
    localparam int LZC_W = $clog2(SUM_W);
    localparam int EW2   = EXP_W + 2;
    localparam int RB_W  = SUM_W - MANT_W - 1;
    localparam logic signed [EW2-1:0] EMAX = EW2'(2**(EXP_W-1) - 1);
    localparam logic signed [EW2-1:0] EMIN = EW2'(-(2**(EXP_W-1)));

    logic              s1_en, s2_en;

    logic              s1_valid_q;
    logic [SUM_W-1:0]  s1_sum_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [LZC_W-1:0]  s1_lzc_q;
    logic              s1_zero_q;
    logic [LZC_W-1:0]  lzc_d;

    logic              out_valid_q;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              zero_q, ovf_q, unf_q;
    logic              ovf_d, unf_d;

    logic [SUM_W-1:0]  sh;
    logic [MANT_W-1:0] m;
    logic              g, s, rnd, carry;
    logic [MANT_W:0]   m_inc;
    logic [EW2-1:0]    e_w;

    assign s2_en        = ~out_valid_q | bus.out_ready;
    assign s1_en        = ~s1_valid_q | s2_en;
    assign bus.in_ready = s1_en;

    // Leading-zero count: the highest set bit wins (last assignment)
    always_comb begin
        lzc_d = '0;
        for (int unsigned i = 0; i < SUM_W; i++) begin
            if (bus.sum_in[i]) lzc_d = LZC_W'(SUM_W - 1 - i);
        end
    end

    // Stage 1 capture
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_exp_q   <= '0;
            s1_lzc_q   <= '0;
            s1_zero_q  <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sum_q  <= bus.sum_in;
                s1_exp_q  <= bus.exp_in;
                s1_lzc_q  <= lzc_d;
                s1_zero_q <= (bus.sum_in == '0);
            end
        end
    end

    // Normalize, round to nearest-even, adjust exponent and range flags
    always_comb begin
        sh    = s1_sum_q << s1_lzc_q;
        m     = sh[SUM_W-1 -: MANT_W];
        g     = sh[RB_W];
        s     = |sh[RB_W-1:0];
        rnd   = g & (s | m[0]);
        m_inc = {1'b0, m} + {{MANT_W{1'b0}}, rnd};
        carry = m_inc[MANT_W];
        e_w   = {{2{s1_exp_q[EXP_W-1]}}, s1_exp_q} + EW2'(SUM_W - MANT_W)
                - EW2'(s1_lzc_q) + EW2'(carry);
        mant_d = carry ? {1'b1, {(MANT_W-1){1'b0}}} : m_inc[MANT_W-1:0];
        exp_d  = e_w[EXP_W-1:0];
        ovf_d  = $signed(e_w) > EMAX;
        unf_d  = $signed(e_w) < EMIN;
        if (s1_zero_q) begin
            mant_d = '0;
            exp_d  = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end
    end

    // Stage 2 output registers, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            mant_q      <= '0;
            exp_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                mant_q <= mant_d;
                exp_q  <= exp_d;
                zero_q <= s1_zero_q;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.mant_out  = mant_q;
    assign bus.exp_out   = exp_q;
    assign bus.zero_out  = zero_q;
    assign bus.ovf_out   = ovf_q;
    assign bus.unf_out   = unf_q;

`ifdef NORM_INEXACT_EN
    logic inexact_q;

    // Inexact flag travels with the mantissa; g and s are both 0 for zero input
    always_ff @(posedge clk) begin
        if (reset) begin
            inexact_q <= 1'b0;
        end else if (s2_en && s1_valid_q) begin
            inexact_q <= g | s;
        end
    end

    assign bus.inexact_out = inexact_q;
`endif
endmodule
